rca_seq: RTL and testbench
==========================

Name: rca_seq

Overview:
Multi-cycle N-bit adder/subtractor for the fault-injection campaign. It reuses one CHUNK-bit ripple-carry datapath, built from FA cells, over WIDTH/CHUNK cycles. The carry is held in a register between chunks. The gate-level fault bus is applied to the shared chunk datapath, so one stuck gate corrupts every chunk it processes. It sits between the campaign stimulus driver and the result comparator, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits added per cycle (number of FA cells); must be >= 2
NG, 128, width of the fault-enable bus
GID_BASE, 0, first gate ID used; IDs GID_BASE .. GID_BASE+2*CHUNK-1 are used and must be < NG

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand request
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (ignored when sub=1)
sub  in  1  1 = A-B, 0 = A+B+cin
fault_en_bus  in  NG  per-gate fault enable
fault_val  in  1  value forced onto enabled gate outputs
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
s  out  WIDTH  sum/difference
cout  out  1  carry-out of MSB
ovf  out  1  signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset, sampled at the clk edge while rst_n=0:
  - state goes to IDLE, the chunk counter to 0.
  - operand shift registers, s, cout, ovf and the carry register all go to 0.
  - out_valid=0.
  - in_ready=0 while rst_n=0.
  - A reset mid-RUN or mid-DONE abandons the transaction and produces no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&in_ready, latch a into a_sh and (sub ? ~b : b) into b_sh.
  - Set carry_reg = sub ? 1 : cin and cnt=0, then go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the chunk datapath adds a_sh[CHUNK-1:0] + b_sh[CHUNK-1:0] + carry_reg.
  - Both a_sh and b_sh shift right by CHUNK.
  - The chunk sum shifts into the top of s_sh, and the chunk carry-out goes to carry_reg.
  - cnt increments each cycle.
  - On the cycle where cnt = WIDTH/CHUNK-1:
    - cout <= chunk carry-out.
    - ovf <= carry into the chunk MSB XOR chunk carry-out.
    - State goes to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - s, cout and ovf are held stable while out_ready=0; in_valid is ignored.
  - On out_ready=1, go to IDLE the next cycle. No same-cycle re-accept.
- Latency: out_valid rises WIDTH/CHUNK cycles after the accepting edge (4 for the defaults). Throughput is one result per WIDTH/CHUNK+2 cycles minimum.
- Fault semantics are those of FA:
  - FA k in the chunk has its sum gate ID at GID_BASE+2k and its cout gate ID at GID_BASE+2k+1.
  - An enabled gate output is replaced by fault_val.
  - Faults are combinational and live. Changing fault_en_bus mid-RUN affects only the chunks computed after the change.
  - Faults do not touch the registers or the FSM.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Subtraction is A + ~B + 1.
  - cout for subtraction means "no borrow".
- Illegal parameters (WIDTH % CHUNK != 0, CHUNK < 2, GID_BASE+2*CHUNK > NG) must fail elaboration.

Decomposition:
- Shared package holds:
  - the state enum: IDLE, RUN, DONE.
  - the constant function NCH = WIDTH/CHUNK.
  - the counter width $clog2(NCH).
- Sub-module rca_chunk, parametrised by CHUNK, NG and GID_BASE:
  - a combinational chain of CHUNK FA instances with gate IDs assigned as above.
  - outputs: chunk sum, carry-out, and carry into the MSB (needed for ovf).
- rca_seq holds the FSM, shift registers, counter and carry register.

Test Plan:
1. Defaults, a=16'h1234, b=16'h4321, cin=0, sub=0 -> in_ready low for 4 RUN cycles; out_valid rises 4 cycles after accept; s=16'h5555, cout=0, ovf=0.
2. a=16'hFFFF, b=16'h0001, cin=0 -> s=16'h0000, cout=1, ovf=0. Confirms the carry passes through carry_reg across all 4 chunks.
3. sub=1, a=16'h8000, b=16'h0001 -> s=16'h7FFF, cout=1, ovf=1. Also sub=1, a=16'h0003, b=16'h0005 -> s=16'hFFFE, cout=0, ovf=0.
4. fault_en_bus[GID_BASE+0]=1, fault_val=0, a=16'h1111, b=0 -> s=16'h0000: FA0 sum is stuck at 0 in every chunk. The same transaction with no faults gives s=16'h1111.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE and pulse in_valid -> s/cout/ovf stable and in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
6. rst_n=0 for one edge during RUN cycle 2 -> next cycle state IDLE, out_valid=0, s=0, in_ready=1 after rst_n=1. A following transaction (test 1 operands) gives s=16'h5555.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg: shared definitions for the multi-cycle ripple-carry adder.
//   state_e : controller states
//   nch()   : number of chunk passes per operation (WIDTH/CHUNK)
//   cnt_w() : chunk counter width, at least 1 bit
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cnt_w(input int width, input int chunk);
    return (width / chunk > 1) ? $clog2(width / chunk) : 1;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple-carry chain of full adders with
// gate-level fault injection.
//   a_i, b_i     : chunk operands
//   c_i          : carry into FA0
//   fault_en_bus : per-gate fault enable (FA k: sum gate GID_BASE+2k,
//                  carry gate GID_BASE+2k+1)
//   fault_val    : value forced onto every enabled gate output
//   sum_o        : chunk sum
//   cout_o       : carry out of the MSB FA
//   cmsb_o       : carry into the MSB FA (for signed overflow)
module rca_chunk #(
  parameter int CHUNK    = 4,
  parameter int NG       = 128,
  parameter int GID_BASE = 0
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  input  logic [NG-1:0]    fault_en_bus,
  input  logic             fault_val,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  if (CHUNK < 2) begin : g_bad_chunk
    $error("rca_chunk: CHUNK must be >= 2");
  end
  if (GID_BASE < 0 || GID_BASE + 2*CHUNK > NG) begin : g_bad_gid
    $error("rca_chunk: gate IDs GID_BASE..GID_BASE+2*CHUNK-1 must lie inside the fault bus");
  end

  logic [CHUNK:0] carry;
  assign carry[0] = c_i;

  for (genvar k = 0; k < CHUNK; k++) begin : g_fa
    localparam int GID_S = GID_BASE + 2*k;
    localparam int GID_C = GID_BASE + 2*k + 1;
    logic sum_raw, co_raw;
    assign sum_raw      = a_i[k] ^ b_i[k] ^ carry[k];
    assign co_raw       = (a_i[k] & b_i[k]) | (carry[k] & (a_i[k] ^ b_i[k]));
    assign sum_o[k]     = fault_en_bus[GID_S] ? fault_val : sum_raw;
    assign carry[k+1]   = fault_en_bus[GID_C] ? fault_val : co_raw;
  end

  assign cout_o = carry[CHUNK];
  assign cmsb_o = carry[CHUNK-1];

  // Only 2*CHUNK bits of the campaign-wide bus belong to this chunk.
  logic unused_fault_bits;
  assign unused_fault_bits = ^fault_en_bus;

endmodule

// File: rtl/rca_seq.sv
// rca_seq: WIDTH-bit adder/subtractor that reuses one CHUNK-bit faultable
// ripple-carry datapath over WIDTH/CHUNK cycles.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operand handshake (a, b, cin, sub)
//   fault_en_bus, fault_val : live gate-level faults on the shared chunk
//   out_valid / out_ready : result handshake (s, cout, ovf)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one chunk per cycle, LSB chunk first
// DONE  | result held until out_ready
module rca_seq
  import rca_seq_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter int NG       = 128,
  parameter int GID_BASE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [NG-1:0]    fault_en_bus,
  input  logic             fault_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  if (CHUNK < 2 || WIDTH % CHUNK != 0) begin : g_bad_width
    $error("rca_seq: WIDTH must be a multiple of CHUNK and CHUNK >= 2");
  end

  localparam int NCH_P = nch(WIDTH, CHUNK);
  localparam int CW    = cnt_w(WIDTH, CHUNK);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout, ch_cmsb;

  rca_chunk #(
    .CHUNK   (CHUNK),
    .NG      (NG),
    .GID_BASE(GID_BASE)
  ) u_chunk (
    .a_i         (a_sh_q[CHUNK-1:0]),
    .b_i         (b_sh_q[CHUNK-1:0]),
    .c_i         (carry_q),
    .fault_en_bus(fault_en_bus),
    .fault_val   (fault_val),
    .sum_o       (ch_sum),
    .cout_o      (ch_cout),
    .cmsb_o      (ch_cmsb)
  );

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_sh_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub | cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        // Each chunk enters at the top, so after NCH passes the LSB chunk
        // has been pushed down to bit 0.
        s_sh_d  = (s_sh_q >> CHUNK) | (WIDTH'(ch_sum) << (WIDTH - CHUNK));
        carry_d = ch_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NCH_P - 1)) begin
          cout_d  = ch_cout;
          ovf_d   = ch_cmsb ^ ch_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_rca_seq.sv
module tb_rca_seq;

  localparam int WIDTH    = 16;
  localparam int CHUNK    = 4;
  localparam int NG       = 128;
  localparam int GID_BASE = 0;
  localparam int LAT      = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic [NG-1:0]    fault_en_bus;
  logic             fault_val;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout, ovf;

  always #5 clk = ~clk;

  rca_seq #(
    .WIDTH   (WIDTH),
    .CHUNK   (CHUNK),
    .NG      (NG),
    .GID_BASE(GID_BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .fault_en_bus(fault_en_bus),
    .fault_val   (fault_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .s           (s),
    .cout        (cout),
    .ovf         (ovf)
  );

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } res_t;

  res_t sb_q[$];
  res_t exp_r;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv);
    res_t           r;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    bb     = sv ? ~bv : bv;
    full   = {1'b0, av} + {1'b0, bb} + {{WIDTH{1'b0}}, (sv ? 1'b1 : cv)};
    r.s    = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (av[WIDTH-1] == bb[WIDTH-1]) && (r.s[WIDTH-1] != av[WIDTH-1]);
    return r;
  endfunction

  // Present operands in IDLE and let the next edge accept them.
  task automatic send(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic cv, input logic sv);
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then compare against the scoreboard head.
  task automatic collect(input string tag);
    int cyc    = 0;
    bit ir_bad = 0;
    while (!out_valid && cyc < 20) begin
      if (in_ready !== 1'b0) ir_bad = 1;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(LAT));
    chk({tag, ".in_ready_run"}, 32'(ir_bad), 32'd0);
    if (sb_q.size() > 0) exp_r = sb_q.pop_front();
    else exp_r = '0;
    chk({tag, ".s"}, 32'(s), 32'(exp_r.s));
    chk({tag, ".cout"}, 32'(cout), 32'(exp_r.cout));
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_r.ovf));
  endtask

  task automatic release_res(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_low"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic txn(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                     input logic cv, input logic sv);
    sb_q.push_back(model(av, bv, cv, sv));
    send(tag, av, bv, cv, sv);
    collect(tag);
    release_res(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    fault_en_bus = '0; fault_val = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.s", 32'(s), 32'd0);
    chk("rst.cout_ovf", {30'd0, cout, ovf}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready_after", 32'(in_ready), 32'd1);

    // Basic add, carry across all chunks, subtraction cases
    txn("t1_add", 16'h1234, 16'h4321, 1'b0, 1'b0);
    txn("t2_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    txn("t3_sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
    txn("t3_sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1);
    txn("t3_sub_cin_ignored", 16'h0003, 16'h0005, 1'b1, 1'b1);
    txn("t_cin", 16'h7FFF, 16'h0000, 1'b1, 1'b0);

    // FA0 sum stuck at 0 in every chunk
    fault_en_bus[GID_BASE + 0] = 1'b1;
    fault_val = 1'b0;
    sb_q.push_back('{s: 16'h0000, cout: 1'b0, ovf: 1'b0});
    send("t4_fault", 16'h1111, 16'h0000, 1'b0, 1'b0);
    collect("t4_fault");
    release_res("t4_fault");
    fault_en_bus = '0;
    txn("t4_nofault", 16'h1111, 16'h0000, 1'b0, 1'b0);

    // Backpressure in DONE with in_valid pulsed
    sb_q.push_back(model(16'hABCD, 16'h1357, 1'b1, 1'b0));
    send("t5_bp", 16'hABCD, 16'h1357, 1'b1, 1'b0);
    collect("t5_bp");
    begin
      bit bad = 0;
      in_valid = 1'b1;
      a = 16'h0F0F; b = 16'hF0F0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== exp_r.s ||
            cout !== exp_r.cout || ovf !== exp_r.ovf) bad = 1;
        in_valid = (i == 0) ? 1'b0 : 1'b1;
      end
      in_valid = 1'b0;
      chk("t5_bp.hold_stable", 32'(bad), 32'd0);
    end
    release_res("t5_bp");

    // Reset during RUN cycle 2 abandons the transaction
    send("t6_abort", 16'h1234, 16'h4321, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6.in_ready_in_rst", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t6.out_valid", 32'(out_valid), 32'd0);
    chk("t6.s", 32'(s), 32'd0);
    chk("t6.in_ready", 32'(in_ready), 32'd1);
    begin
      bit seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1;
      end
      chk("t6.no_output", 32'(seen), 32'd0);
    end
    txn("t6_after", 16'h1234, 16'h4321, 1'b0, 1'b0);

    // A few random operands
    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic rc, rs;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      txn("rand", ra, rb, rc, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
